// File: rtl/csr_rmw_sequencer.sv
// ============================================================================
// Module   : csr_rmw_sequencer
// Purpose  : Sequences Zicsr read-modify-write instructions against a CSR file.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csr_rmw_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1,
    input  logic [XLEN-1:0] req_rs1_rdata,
    input  logic [4:0]      req_rd,
    input  logic [1:0]      req_mode,
    input  logic            req_unimpl,
    output logic            csr_ren,
    output logic [11:0]     csr_raddr,
    input  logic            csr_rvalid,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_trap,
    output logic [4:0]      rsp_rd,
    output logic [XLEN-1:0] rsp_rd_wdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [1:0]      r_op;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_arg;
    logic [4:0]      r_rd;
    logic            r_wr;
    logic            r_trap;
    logic [XLEN-1:0] r_old;

    logic            w_accept;
    logic [XLEN-1:0] w_arg;
    logic            w_wr;
    logic            w_illegal;
    logic            w_skip_read;
    logic [XLEN-1:0] w_new;

    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_arg       = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1} : req_rs1_rdata;
    assign w_wr        = !req_funct3[1] || (req_rs1 != 5'd0);
    // Privilege field addr[9:8] must not exceed the current mode; 2 is reserved.
    assign w_illegal   = (req_funct3[1:0] == 2'b00) || req_unimpl
                      || (req_addr[9:8] > req_mode) || (req_addr[9:8] == 2'b10)
                      || ((req_addr[11:10] == 2'b11) && w_wr);
    assign w_skip_read = (req_funct3[1:0] == 2'b01) && (req_rd == 5'd0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_op    <= 2'b00;
            r_addr  <= 12'd0;
            r_arg   <= '0;
            r_rd    <= 5'd0;
            r_wr    <= 1'b0;
            r_trap  <= 1'b0;
            r_old   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= req_funct3[1:0];
                r_addr <= req_addr;
                r_arg  <= w_arg;
                r_rd   <= req_rd;
                r_wr   <= w_wr;
                r_trap <= w_illegal;
                r_old  <= '0;
            end
            if ((r_state == WAIT) && csr_rvalid) begin
                r_old <= csr_rdata;
            end
        end
    end

    always_comb begin
        w_new = r_arg;
        case (r_op)
            2'b10:   w_new = r_old | r_arg;
            2'b11:   w_new = r_old & ~r_arg;
            default: w_new = r_arg;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        csr_ren      = 1'b0;
        csr_raddr    = 12'd0;
        csr_wen      = 1'b0;
        csr_waddr    = 12'd0;
        csr_wdata    = '0;
        rsp_valid    = 1'b0;
        rsp_trap     = 1'b0;
        rsp_rd       = 5'd0;
        rsp_rd_wdata = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_illegal)        w_next = RESP;
                    else if (w_skip_read) w_next = WRITE;
                    else                  w_next = READ;
                end
            end
            READ: begin
                csr_ren   = 1'b1;
                csr_raddr = r_addr;
                w_next    = WAIT;
            end
            WAIT: begin
                if (csr_rvalid) w_next = r_wr ? WRITE : RESP;
            end
            WRITE: begin
                csr_wen   = 1'b1;
                csr_waddr = r_addr;
                csr_wdata = w_new;
                w_next    = RESP;
            end
            RESP: begin
                rsp_valid    = 1'b1;
                rsp_trap     = r_trap;
                rsp_rd       = r_trap ? 5'd0 : r_rd;
                rsp_rd_wdata = (!r_trap && (r_rd != 5'd0)) ? r_old : '0;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

`default_nettype wire
